// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the data-port memory access unit.
// Holds funct3 codes, FSM state encoding, response error codes and request decode.
package mem_access_unit_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRdAddr,
      StRdData,
      StWrite
   } state_e;

   typedef enum logic [1:0] {
      ErrNone     = 2'b00,
      ErrMisalign = 2'b01,
      ErrFunct3   = 2'b10,
      ErrTimeout  = 2'b11
   } resp_err_e;

   localparam logic [2:0] F3Byte  = 3'b000;
   localparam logic [2:0] F3Half  = 3'b001;
   localparam logic [2:0] F3Word  = 3'b010;
   localparam logic [2:0] F3ByteU = 3'b100;
   localparam logic [2:0] F3HalfU = 3'b101;

   // Illegal funct3 is reported ahead of misalignment.
   function automatic resp_err_e check_req(input logic       wen,
                                           input logic [2:0] funct3,
                                           input logic [1:0] offset);
      logic legal;
      if (wen) begin
         legal = (funct3 == F3Byte) || (funct3 == F3Half) || (funct3 == F3Word);
      end else begin
         legal = (funct3 == F3Byte) || (funct3 == F3Half) || (funct3 == F3Word) ||
                 (funct3 == F3ByteU) || (funct3 == F3HalfU);
      end
      if (!legal) begin
         return ErrFunct3;
      end else if (((funct3[1:0] == 2'b10) && (offset != 2'b00)) ||
                   ((funct3[1:0] == 2'b01) && offset[0])) begin
         return ErrMisalign;
      end
      return ErrNone;
   endfunction

   function automatic logic [31:0] store_mask(input logic [2:0] funct3,
                                              input logic [1:0] offset);
      logic [31:0] mask;
      unique case (funct3[1:0])
         2'b00:   mask = 32'h0000_00FF << {offset, 3'b000};
         2'b01:   mask = 32'h0000_FFFF << {offset, 3'b000};
         default: mask = 32'hFFFF_FFFF;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/mem_access_unit_load_extract.sv
// Selects the addressed byte/halfword of a memory word and sign- or zero-extends it.
// Purely combinational; offset and funct3 come from the latched request.
module mem_access_unit_load_extract
   import mem_access_unit_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  offset_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] result_o
);

   logic [31:0] shifted;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      shifted  = rdata_i >> {offset_i, 3'b000};
      byte_sel = shifted[7:0];
      half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      unique case (funct3_i)
         F3Byte:  result_o = {{24{byte_sel[7]}}, byte_sel};
         F3ByteU: result_o = {24'h0, byte_sel};
         F3Half:  result_o = {{16{half_sel[15]}}, half_sel};
         F3HalfU: result_o = {16'h0, half_sel};
         default: result_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// CPU-side load/store initiator for the unified memory data port.
// Issues one access per request and returns an extended load result or store completion.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int unsigned WordLen       = 32,
   parameter int unsigned TimeoutCycles = 15
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               req_valid_i,
   output logic               req_ready_o,
   input  logic               req_wen_i,
   input  logic [2:0]         req_funct3_i,
   input  logic [WordLen-1:0] req_addr_i,
   input  logic [WordLen-1:0] req_wdata_i,
   output logic               resp_valid_o,
   output logic [WordLen-1:0] resp_rdata_o,
   output logic [1:0]         resp_err_o,
   output logic [WordLen-1:0] mem_d_addr_o,
   output logic               mem_wen_o,
   output logic [WordLen-1:0] mem_wmask_o,
   output logic [WordLen-1:0] mem_wdata_o,
   input  logic [WordLen-1:0] mem_rdata_i,
   input  logic               mem_data_ready_i
);

   localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

   state_e            state_q, state_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [1:0]        off_q, off_d;
   logic [WordLen-1:0] d_addr_q, d_addr_d;
   logic [WordLen-1:0] wmask_q, wmask_d;
   logic [WordLen-1:0] wdata_q, wdata_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              resp_valid_q, resp_valid_d;
   logic [WordLen-1:0] resp_rdata_q, resp_rdata_d;
   resp_err_e         resp_err_q, resp_err_d;

   logic              accept;
   resp_err_e         req_err;
   logic              timeout_hit;
   logic [31:0]       load_result;
   logic [WordLen-1:0] new_mask;

   mem_access_unit_load_extract u_load_extract (
      .rdata_i  (mem_rdata_i),
      .offset_i (off_q),
      .funct3_i (funct3_q),
      .result_o (load_result)
   );

   always_comb begin
      accept      = req_valid_i && (state_q == StIdle);
      req_err     = check_req(req_wen_i, req_funct3_i, req_addr_i[1:0]);
      new_mask    = store_mask(req_funct3_i, req_addr_i[1:0]);
      // A zero limit disables the write timeout entirely.
      timeout_hit = (TimeoutCycles != 0) && ((32'(cnt_q) + 32'd1) == TimeoutCycles);
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept && (req_err == ErrNone)) begin
               state_d = req_wen_i ? StWrite : StRdAddr;
            end
         end
         StRdAddr: state_d = StRdData;
         StRdData: state_d = StIdle;
         StWrite: begin
            // Leave on the commit edge so wen never lasts a third cycle.
            if (mem_data_ready_i || timeout_hit) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Output logic
   always_comb begin
      req_ready_o  = (state_q == StIdle);
      mem_wen_o    = (state_q == StWrite);
      mem_d_addr_o = d_addr_q;
      mem_wmask_o  = wmask_q;
      mem_wdata_o  = wdata_q;
      resp_valid_o = resp_valid_q;
      resp_rdata_o = resp_rdata_q;
      resp_err_o   = resp_err_q;
   end

   // Request latch, store lane generation, timeout counter and response
   always_comb begin
      funct3_d     = funct3_q;
      off_d        = off_q;
      d_addr_d     = d_addr_q;
      wmask_d      = wmask_q;
      wdata_d      = wdata_q;
      cnt_d        = cnt_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = '0;
      resp_err_d   = ErrNone;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               funct3_d = req_funct3_i;
               off_d    = req_addr_i[1:0];
               if (req_err != ErrNone) begin
                  resp_valid_d = 1'b1;
                  resp_err_d   = req_err;
               end else begin
                  d_addr_d = {req_addr_i[WordLen-1:2], 2'b00};
                  cnt_d    = '0;
                  if (req_wen_i) begin
                     wmask_d = new_mask;
                     wdata_d = (req_wdata_i << {req_addr_i[1:0], 3'b000}) & new_mask;
                  end
               end
            end
         end
         StRdAddr: ;
         StRdData: begin
            resp_valid_d = 1'b1;
            resp_rdata_d = load_result;
         end
         StWrite: begin
            if (mem_data_ready_i) begin
               resp_valid_d = 1'b1;
            end else if (timeout_hit) begin
               resp_valid_d = 1'b1;
               resp_err_d   = ErrTimeout;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         funct3_q     <= '0;
         off_q        <= '0;
         d_addr_q     <= '0;
         wmask_q      <= '0;
         wdata_q      <= '0;
         cnt_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= ErrNone;
      end else begin
         funct3_q     <= funct3_d;
         off_q        <= off_d;
         d_addr_q     <= d_addr_d;
         wmask_q      <= wmask_d;
         wdata_q      <= wdata_d;
         cnt_q        <= cnt_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit wrapped around a behavioural unified memory.
// Expected results come from a byte-array model of the memory and the access rules.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_wen = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_err;
   logic [31:0] mem_d_addr;
   logic        mem_wen;
   logic [31:0] mem_wmask;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_data_ready;

   logic        stub_nrdy = 1'b0;
   logic        load_init = 1'b1;
   logic [31:0] init_arr [0:255];
   logic [31:0] mem_arr [0:255];
   int          wen_run;
   logic [7:0]  model_mem [0:1023];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_access_unit dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .req_valid_i      (req_valid),
      .req_ready_o      (req_ready),
      .req_wen_i        (req_wen),
      .req_funct3_i     (req_funct3),
      .req_addr_i       (req_addr),
      .req_wdata_i      (req_wdata),
      .resp_valid_o     (resp_valid),
      .resp_rdata_o     (resp_rdata),
      .resp_err_o       (resp_err),
      .mem_d_addr_o     (mem_d_addr),
      .mem_wen_o        (mem_wen),
      .mem_wmask_o      (mem_wmask),
      .mem_wdata_o      (mem_wdata),
      .mem_rdata_i      (mem_rdata),
      .mem_data_ready_i (mem_data_ready)
   );

   // Unified memory: registered read; full-mask writes ready at once, partial on the 2nd cycle.
   assign mem_data_ready = mem_wen && !stub_nrdy && ((mem_wmask == 32'hFFFF_FFFF) || (wen_run >= 1));

   always @(posedge clk) begin
      if (load_init) begin
         for (int i = 0; i < 256; i++) mem_arr[i] <= init_arr[i];
      end else if (mem_wen && mem_data_ready) begin
         mem_arr[mem_d_addr[9:2]] <= (mem_arr[mem_d_addr[9:2]] & ~mem_wmask) |
                                     (mem_wdata & mem_wmask);
      end
      mem_rdata <= mem_arr[mem_d_addr[9:2]];
      if (rst) wen_run <= 0;
      else     wen_run <= mem_wen ? wen_run + 1 : 0;
   end

   // ---------------- reference model ----------------
   function automatic int acc_size(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic logic [1:0] model_err(input logic w, input logic [2:0] f3, input logic [31:0] a);
      logic legal;
      legal = w ? (f3 <= 3'd2) : ((f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5));
      if (!legal) return 2'b10;
      if ((a % acc_size(f3)) != 0) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
      logic [31:0] v;
      int sz;
      sz = acc_size(f3);
      v = 32'd0;
      for (int k = 0; k < sz; k++) v = v | (32'(model_mem[a[9:0] + 10'(k)]) << (8 * k));
      if ((f3 < 3'd4) && (sz < 4) && v[8*sz-1]) v = v | ~((32'd1 << (8 * sz)) - 32'd1);
      return v;
   endfunction

   function automatic logic [31:0] model_mask(input logic [2:0] f3, input logic [31:0] a);
      longint unsigned m;
      m = ((64'd1 << (8 * acc_size(f3))) - 64'd1) << (8 * (a % 4));
      return m[31:0];
   endfunction

   task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      logic [31:0] t;
      for (int k = 0; k < acc_size(f3); k++) begin
         t = d >> (8 * k);
         model_mem[a[9:0] + 10'(k)] = t[7:0];
      end
   endtask

   // Drives one request at the current negedge and waits (bounded) for its response.
   task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] rd, output logic [1:0] er,
                         output int lat, output int wc, output logic [31:0] wm,
                         output logic [31:0] wdt, output logic ok);
      req_valid = 1'b1; req_wen = w; req_funct3 = f3; req_addr = a; req_wdata = d;
      lat = 0; wc = 0; wm = 32'd0; wdt = 32'd0; ok = 1'b0; rd = 32'd0; er = 2'b00;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 1) req_valid = 1'b0;
         if (mem_wen) begin
            wc++; wm = mem_wmask; wdt = mem_wdata;
         end
         if (resp_valid) begin
            lat = i; rd = resp_rdata; er = resp_err; ok = 1'b1;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [31:0] outs [0:7];
      logic [31:0] exp_outs [0:7];
      outs[0] = 32'(req_ready);  exp_outs[0] = 32'd1;
      outs[1] = 32'(resp_valid); exp_outs[1] = 32'd0;
      outs[2] = resp_rdata;      exp_outs[2] = 32'd0;
      outs[3] = 32'(resp_err);   exp_outs[3] = 32'd0;
      outs[4] = 32'(mem_wen);    exp_outs[4] = 32'd0;
      outs[5] = mem_d_addr;      exp_outs[5] = 32'd0;
      outs[6] = mem_wmask;       exp_outs[6] = 32'd0;
      outs[7] = mem_wdata;       exp_outs[7] = 32'd0;
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (outs[i] !== exp_outs[i]) begin
            n_bad++;
            $display("FAIL reset_out%0d got %h want %h", i, outs[i], exp_outs[i]);
         end
      end
   endtask

   task automatic test_loads();
      logic [2:0]  f3s  [0:2];
      logic [31:0] exps [0:2];
      logic [31:0] rd, wm, wdt;
      logic [1:0]  er;
      int          lat, wc;
      logic        ok;
      f3s[0] = 3'b000; exps[0] = 32'hFFFF_FF83;
      f3s[1] = 3'b100; exps[1] = 32'h0000_0083;
      f3s[2] = 3'b001; exps[2] = 32'h0000_4483;
      for (int i = 0; i < 3; i++) begin
         do_req(1'b0, f3s[i], 32'h102, 32'd0, rd, er, lat, wc, wm, wdt, ok);
         n_cmp++;
         if (!ok || rd !== exps[i] || er !== 2'b00 || lat != 3 || wc != 0) begin
            n_bad++;
            $display("FAIL load_f3_%0d got data=%h err=%b lat=%0d wen=%0d want data=%h err=00 lat=3 wen=0",
                     f3s[i], rd, er, lat, wc, exps[i]);
         end
      end
   endtask

   task automatic test_stores();
      logic [31:0] rd, wm, wdt;
      logic [1:0]  er;
      int          lat, wc;
      logic        ok;
      do_req(1'b1, 3'b010, 32'h104, 32'hDEAD_BEEF, rd, er, lat, wc, wm, wdt, ok);
      model_store(3'b010, 32'h104, 32'hDEAD_BEEF);
      n_cmp++;
      if (!ok || wm !== 32'hFFFF_FFFF || wc != 1 || er !== 2'b00 || rd !== 32'd0 || lat != 2) begin
         n_bad++;
         $display("FAIL sw_full got mask=%h wen=%0d err=%b lat=%0d want mask=ffffffff wen=1 err=00 lat=2",
                  wm, wc, er, lat);
      end
      do_req(1'b0, 3'b010, 32'h104, 32'd0, rd, er, lat, wc, wm, wdt, ok);
      n_cmp++;
      if (rd !== 32'hDEAD_BEEF) begin
         n_bad++;
         $display("FAIL sw_readback got %h want deadbeef", rd);
      end
      do_req(1'b1, 3'b000, 32'h101, 32'h0000_00AA, rd, er, lat, wc, wm, wdt, ok);
      model_store(3'b000, 32'h101, 32'h0000_00AA);
      n_cmp++;
      if (!ok || wm !== 32'h0000_FF00 || wdt !== 32'h0000_AA00 || wc != 2 || lat != 3) begin
         n_bad++;
         $display("FAIL sb_partial got mask=%h wdata=%h wen=%0d lat=%0d want mask=0000ff00 wdata=0000aa00 wen=2 lat=3",
                  wm, wdt, wc, lat);
      end
      do_req(1'b0, 3'b010, 32'h100, 32'd0, rd, er, lat, wc, wm, wdt, ok);
      n_cmp++;
      if (rd !== 32'h4483_AA11) begin
         n_bad++;
         $display("FAIL sb_readback got %h want 4483aa11", rd);
      end
   endtask

   task automatic test_errors();
      logic        ws   [0:3];
      logic [2:0]  f3s  [0:3];
      logic [31:0] as   [0:3];
      logic [1:0]  exps [0:3];
      logic [31:0] rd, wm, wdt;
      logic [1:0]  er;
      int          lat, wc;
      logic        ok;
      ws[0] = 1'b0; f3s[0] = 3'b010; as[0] = 32'h102; exps[0] = 2'b01;
      ws[1] = 1'b0; f3s[1] = 3'b011; as[1] = 32'h100; exps[1] = 2'b10;
      ws[2] = 1'b1; f3s[2] = 3'b100; as[2] = 32'h103; exps[2] = 2'b10;
      ws[3] = 1'b1; f3s[3] = 3'b001; as[3] = 32'h101; exps[3] = 2'b01;
      for (int i = 0; i < 4; i++) begin
         do_req(ws[i], f3s[i], as[i], 32'h1234_5678, rd, er, lat, wc, wm, wdt, ok);
         n_cmp++;
         if (!ok || er !== exps[i] || lat != 1 || wc != 0 || rd !== 32'd0) begin
            n_bad++;
            $display("FAIL err_case%0d got err=%b lat=%0d wen=%0d data=%h want err=%b lat=1 wen=0 data=0",
                     i, er, lat, wc, rd, exps[i]);
         end
      end
   endtask

   task automatic test_timeout();
      logic [31:0] rd, wm, wdt;
      logic [1:0]  er;
      int          lat, wc;
      logic        ok;
      stub_nrdy = 1'b1;
      do_req(1'b1, 3'b001, 32'h100, 32'h0000_BEEF, rd, er, lat, wc, wm, wdt, ok);
      n_cmp++;
      if (!ok || er !== 2'b11 || wc != 15 || lat != 16 || mem_wen !== 1'b0) begin
         n_bad++;
         $display("FAIL timeout got err=%b wen_cycles=%0d lat=%0d wen_now=%b want err=11 wen_cycles=15 lat=16 wen_now=0",
                  er, wc, lat, mem_wen);
      end
      stub_nrdy = 1'b0;
      n_cmp++;
      if (mem_d_addr !== 32'h100) begin
         n_bad++;
         $display("FAIL idle_addr_hold got %h want 00000100", mem_d_addr);
      end
      do_req(1'b0, 3'b010, 32'h100, 32'd0, rd, er, lat, wc, wm, wdt, ok);
      n_cmp++;
      if (rd !== model_load(3'b010, 32'h100)) begin
         n_bad++;
         $display("FAIL timeout_no_write got %h want %h", rd, model_load(3'b010, 32'h100));
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd, wm, wdt;
      logic [1:0]  er;
      int          lat, wc;
      logic        ok;
      logic        seen;
      req_valid = 1'b1; req_wen = 1'b1; req_funct3 = 3'b000; req_addr = 32'h101;
      req_wdata = 32'h55;
      @(negedge clk);
      req_valid = 1'b0;
      n_cmp++;
      if (mem_wen !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_mid_first_wen got %b want 1", mem_wen);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++;
      if (mem_wen !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_mid_state got wen=%b ready=%b resp=%b want wen=0 ready=1 resp=0",
                  mem_wen, req_ready, resp_valid);
      end
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (resp_valid || mem_wen) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_mid_quiet got activity=%b want 0", seen);
      end
      do_req(1'b0, 3'b010, 32'h100, 32'd0, rd, er, lat, wc, wm, wdt, ok);
      n_cmp++;
      if (rd !== model_load(3'b010, 32'h100)) begin
         n_bad++;
         $display("FAIL rst_mid_word got %h want %h", rd, model_load(3'b010, 32'h100));
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd, wm, wdt;
      logic [1:0]  er;
      int          lat, wc;
      logic        ok;
      do_req(1'b1, 3'b001, 32'h10A, 32'h0000_C3A5, rd, er, lat, wc, wm, wdt, ok);
      model_store(3'b001, 32'h10A, 32'h0000_C3A5);
      n_cmp++;
      if (!(resp_valid === 1'b1 && req_ready === 1'b1)) begin
         n_bad++;
         $display("FAIL b2b_overlap got resp=%b ready=%b want 1 1", resp_valid, req_ready);
      end
      do_req(1'b0, 3'b001, 32'h10A, 32'd0, rd, er, lat, wc, wm, wdt, ok);
      n_cmp++;
      if (!ok || rd !== model_load(3'b001, 32'h10A) || lat != 3) begin
         n_bad++;
         $display("FAIL b2b_load got %h lat=%0d want %h lat=3", rd, lat, model_load(3'b001, 32'h10A));
      end
   endtask

   task automatic test_random();
      logic [31:0] rd, wm, wdt, a, d, exp_rd, exp_m;
      logic [1:0]  er, exp_er;
      logic [2:0]  f3;
      logic        w, ok;
      int          lat, wc, exp_lat, exp_wc;
      for (int n = 0; n < 120; n++) begin
         w  = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         a  = 32'h100 + $urandom_range(0, 63);
         d  = $urandom;
         exp_er = model_err(w, f3, a);
         exp_rd = 32'd0; exp_m = 32'd0;
         if (exp_er != 2'b00) begin
            exp_lat = 1; exp_wc = 0;
         end else if (!w) begin
            exp_lat = 3; exp_wc = 0; exp_rd = model_load(f3, a);
         end else begin
            exp_m = model_mask(f3, a);
            exp_wc = (acc_size(f3) == 4) ? 1 : 2;
            exp_lat = exp_wc + 1;
         end
         do_req(w, f3, a, d, rd, er, lat, wc, wm, wdt, ok);
         if (w && exp_er == 2'b00) model_store(f3, a, d);
         n_cmp++;
         if (!ok || rd !== exp_rd || er !== exp_er || lat != exp_lat || wc != exp_wc ||
             wm !== exp_m || ((wdt & exp_m) !== ((d << (8 * (a % 4))) & exp_m))) begin
            n_bad++;
            $display("FAIL rand%0d w=%b f3=%b a=%h got data=%h err=%b lat=%0d wen=%0d mask=%h wdata=%h want data=%h err=%b lat=%0d wen=%0d mask=%h",
                     n, w, f3, a, rd, er, lat, wc, wm, wdt, exp_rd, exp_er, exp_lat, exp_wc, exp_m);
         end
      end
   endtask

   initial begin
      logic [31:0] w;
      for (int i = 0; i < 256; i++) begin
         w = (i == 64) ? 32'h4483_2211 : $urandom;
         init_arr[i] = w;
         for (int k = 0; k < 4; k++) model_mem[4 * i + k] = 8'(w >> (8 * k));
      end
      rst = 1'b1; load_init = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0; load_init = 1'b0;
      @(negedge clk);
      test_reset();
      test_loads();
      test_stores();
      test_errors();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
